// File: rtl/mem_target_if.sv
// Data-memory bus between the core (master) and mem_target (slave).
//
// Handshake: the master raises ram_read or ram_write (a level, with addr_bus
// and data_in stable) and holds it until it sees mem_ready. mem_busy is high
// while an accepted request is still in progress. mem_ready is a one-cycle
// completion pulse, and read data on mem_bus is valid in that cycle. The
// master must drop its strobe no later than the cycle after mem_ready. The
// slave ignores that cycle, so a strobe that lingers is not taken as a new
// request.
interface mem_target_if;
  logic [15:0] addr_bus;
  logic [15:0] data_in;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] mem_bus;
  logic        mem_busy;
  logic        mem_ready;

  modport master (
    output addr_bus, data_in, ram_read, ram_write,
    input  mem_bus, mem_busy, mem_ready
  );

  modport slave (
    input  addr_bus, data_in, ram_read, ram_write,
    output mem_bus, mem_busy, mem_ready
  );
endinterface

// File: rtl/mem_target.sv
// mem_target: memory-side responder for the core's data bus. It serves word
// RAM and a 4-register MMIO window (LED, TIMER, SCRATCH, STATUS) and inserts
// a fixed number of wait states before the completion pulse.
module mem_target #(
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,
  mem_target_if.slave       bus,
  output logic [7:0]        leds,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_READY   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  localparam int          RAM_WORDS = 1 << DEPTH_LOG2;
  localparam logic [16:0] RAM_END   = 17'(RAM_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [15:0] cap_addr, cap_data;
  logic        cap_write, cap_both;
  logic [15:0] timer, timer_snap, scratch, mem_bus_q;
  logic [7:0]  led_reg;
  logic [15:0] ram [RAM_WORDS];

  logic        accept, commit;
  logic [15:0] op_addr, op_data, op_timer, mmio_off, rd_data;
  logic        op_write, op_both, in_ram, in_mmio, err_set, err_clr, mmio_wr;
  logic [1:0]  reg_sel;
  logic [DEPTH_LOG2-1:0] ram_idx;

  // Next-state logic. commit marks the edge that enters READY, where writes
  // land and read data is registered.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.ram_read || bus.ram_write) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = S_READY;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = S_READY;
          commit    = 1'b1;
        end
      end
      S_READY:   state_nxt = S_RECOVER;
      S_RECOVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Operand select. With zero wait states the commit edge is the acceptance
  // edge, so the live bus and the live timer stand in for the captured copies.
  always_comb begin
    op_addr  = (state == S_IDLE) ? bus.addr_bus : cap_addr;
    op_data  = (state == S_IDLE) ? bus.data_in  : cap_data;
    op_write = (state == S_IDLE) ? bus.ram_write : cap_write;
    op_both  = (state == S_IDLE) ? (bus.ram_read && bus.ram_write) : cap_both;
    op_timer = (state == S_IDLE) ? timer : timer_snap;
  end

  // Address decode, read mux and error bookkeeping for the committing access.
  always_comb begin
    ram_idx  = op_addr[DEPTH_LOG2-1:0];
    in_ram   = ({1'b0, op_addr} < RAM_END);
    mmio_off = op_addr - MMIO_BASE;
    in_mmio  = !in_ram && (mmio_off[15:2] == 14'd0);
    reg_sel  = mmio_off[1:0];
    rd_data  = 16'h0000;
    if (in_ram) begin
      rd_data = ram[ram_idx];
    end else if (in_mmio) begin
      case (reg_sel)
        2'd0:    rd_data = {8'h00, led_reg};
        2'd1:    rd_data = op_timer;
        2'd2:    rd_data = scratch;
        default: rd_data = {15'd0, err};
      endcase
    end
    mmio_wr = commit && op_write && in_mmio;
    err_set = commit && (op_both || (!in_ram && !in_mmio));
    err_clr = mmio_wr && (reg_sel == 2'd3) && op_data[0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Request capture at acceptance and the wait-state countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr   <= 16'h0000;
      cap_data   <= 16'h0000;
      cap_write  <= 1'b0;
      cap_both   <= 1'b0;
      timer_snap <= 16'h0000;
      wait_cnt   <= 4'd0;
    end else if (accept) begin
      cap_addr   <= bus.addr_bus;
      cap_data   <= bus.data_in;
      cap_write  <= bus.ram_write;
      cap_both   <= bus.ram_read && bus.ram_write;
      timer_snap <= timer;
      wait_cnt   <= WAIT_LOAD;
    end else if (state == S_WAIT) begin
      wait_cnt   <= wait_cnt - 4'd1;
    end
  end

  // RAM write port. The contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (commit && op_write && in_ram) ram[ram_idx] <= op_data;
  end

  // Read data register. It changes only when a read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      mem_bus_q <= 16'h0000;
    else if (commit && !op_write) mem_bus_q <= rd_data;
  end

  // MMIO registers: free-running timer, LED/scratch writes, and the sticky
  // error flag, where a set beats a clear on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= 16'h0000;
      led_reg <= 8'h00;
      scratch <= 16'h0000;
      err     <= 1'b0;
    end else begin
      timer <= timer + 16'd1;
      if (mmio_wr) begin
        case (reg_sel)
          2'd0:    led_reg <= op_data[7:0];
          2'd1:    timer   <= 16'h0000;
          2'd2:    scratch <= op_data;
          default: ;
        endcase
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign bus.mem_bus   = mem_bus_q;
  assign bus.mem_busy  = (state == S_WAIT);
  assign bus.mem_ready = (state == S_READY);
  assign leds          = led_reg;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_target.sv
// Bench for mem_target: a 2-wait-state instance driven from a vector table,
// a 0-wait-state instance for back-to-back timing, and hand sequences for
// the timer, timer wrap and reset in the middle of an access.
module tb_mem_target;

  localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_BOTH = 2'd2;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_target_if bus();
  mem_target_if bus0();
  logic [7:0] leds, leds0;
  logic       err, err0;
  logic [1:0] dbg, dbg0;

  mem_target #(.DEPTH_LOG2(12), .WAIT_STATES(2), .MMIO_BASE(16'hFF00)) dut (
    .clk(clk), .rst(rst), .bus(bus), .leds(leds), .err(err), .dbg_state(dbg)
  );

  mem_target #(.DEPTH_LOG2(12), .WAIT_STATES(0), .MMIO_BASE(16'hFF00)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .leds(leds0), .err(err0), .dbg_state(dbg0)
  );

  // Scoreboard state.
  logic [15:0] exp_q[$];
  logic [15:0] last_rd [2];
  int n_checks = 0;
  int n_fail   = 0;
  int timer_zero_cyc = 0;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
    logic [7:0]  exp_leds;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] kind, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] exp_rd, input logic exp_err, input logic [7:0] exp_leds);
    vec_t v;
    v.kind = kind; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_leds = exp_leds;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (sel) begin
      bus0.ram_read = rd; bus0.ram_write = wr; bus0.addr_bus = addr; bus0.data_in = wdata;
    end else begin
      bus.ram_read = rd; bus.ram_write = wr; bus.addr_bus = addr; bus.data_in = wdata;
    end
  endtask

  // One complete access. It is called at a negedge with the target idle and
  // returns at a negedge with the target idle again. The expected mem_bus is
  // pushed at drive time: read data for a read, otherwise the previous read's
  // value, since writes leave mem_bus alone.
  task automatic access(input bit sel, input logic [1:0] kind, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input bit timer_rd, input string tag);
    int w, busy_n, ready_at;
    logic [15:0] got, exp;
    w = sel ? 0 : 2;
    if (kind == K_RD) begin
      exp = timer_rd ? 16'(cyc - timer_zero_cyc) : exp_rd;
      last_rd[sel] = exp;
    end else begin
      exp = last_rd[sel];
    end
    exp_q.push_back(exp);
    drive(sel, kind != K_WR, kind != K_RD, addr, wdata);
    busy_n = 0; ready_at = 0; got = 16'h0;
    for (int k = 1; k <= 20 && ready_at == 0; k++) begin
      @(posedge clk); @(negedge clk);
      if (sel ? bus0.mem_ready : bus.mem_ready) begin
        ready_at = k;
        got = sel ? bus0.mem_bus : bus.mem_bus;
        if (sel ? bus0.mem_busy : bus.mem_busy) busy_n += 100;
      end else if (sel ? bus0.mem_busy : bus.mem_busy) begin
        busy_n++;
      end
    end
    if (!sel && kind != K_RD && addr == 16'hFF01) timer_zero_cyc = cyc;
    drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
    check($sformatf("%s ready_latency", tag), ready_at, w + 1);
    check($sformatf("%s busy_cycles", tag), busy_n, w);
    if (exp_q.size() > 0) check($sformatf("%s mem_bus", tag), got, exp_q.pop_front());
    else check($sformatf("%s scoreboard_empty", tag), 1, 0);
    @(posedge clk); @(negedge clk);
    check($sformatf("%s recover_no_ready", tag), sel ? bus0.mem_ready : bus.mem_ready, 0);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rdy_n, busy_n;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", bus.mem_busy, 0);
    check("reset ready", bus.mem_ready, 0);
    check("reset mem_bus", bus.mem_bus, 16'h0);
    check("reset leds", leds, 8'h00);
    check("reset err", err, 0);
    check("reset state", dbg, 2'd0);
    check("reset mem_bus w0", bus0.mem_bus, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table for the 2-wait-state target.
    add(K_WR,   16'h0010, 16'hBEEF, 16'h0000, 1'b0, 8'h00);
    add(K_RD,   16'h0010, 16'h0000, 16'hBEEF, 1'b0, 8'h00);
    add(K_WR,   16'hFF00, 16'h12A5, 16'h0000, 1'b0, 8'hA5);
    add(K_RD,   16'hFF00, 16'h0000, 16'h00A5, 1'b0, 8'hA5);
    add(K_WR,   16'hFF02, 16'hCAFE, 16'h0000, 1'b0, 8'hA5);
    add(K_RD,   16'hFF02, 16'h0000, 16'hCAFE, 1'b0, 8'hA5);
    add(K_RD,   16'h8000, 16'h0000, 16'h0000, 1'b1, 8'hA5);
    add(K_RD,   16'hFF03, 16'h0000, 16'h0001, 1'b1, 8'hA5);
    add(K_WR,   16'hFF03, 16'h0000, 16'h0000, 1'b1, 8'hA5);
    add(K_WR,   16'hFF03, 16'hFFFE, 16'h0000, 1'b1, 8'hA5);
    add(K_WR,   16'hFF03, 16'h0001, 16'h0000, 1'b0, 8'hA5);
    add(K_BOTH, 16'h0030, 16'h1234, 16'h0000, 1'b1, 8'hA5);
    add(K_RD,   16'h0030, 16'h0000, 16'h1234, 1'b1, 8'hA5);
    add(K_WR,   16'hFF03, 16'h0001, 16'h0000, 1'b0, 8'hA5);
    add(K_WR,   16'h8000, 16'h1111, 16'h0000, 1'b1, 8'hA5);
    add(K_WR,   16'hFF03, 16'h0001, 16'h0000, 1'b0, 8'hA5);
    add(K_WR,   16'h0000, 16'h0F0F, 16'h0000, 1'b0, 8'hA5);
    add(K_WR,   16'h0FFF, 16'hABCD, 16'h0000, 1'b0, 8'hA5);
    add(K_RD,   16'h0FFF, 16'h0000, 16'hABCD, 1'b0, 8'hA5);
    add(K_WR,   16'h1000, 16'h2222, 16'h0000, 1'b1, 8'hA5);
    add(K_RD,   16'h0000, 16'h0000, 16'h0F0F, 1'b1, 8'hA5);
    add(K_WR,   16'hFF04, 16'h3333, 16'h0000, 1'b1, 8'hA5);
    add(K_RD,   16'hFEFF, 16'h0000, 16'h0000, 1'b1, 8'hA5);
    add(K_RD,   16'hFF00, 16'h0000, 16'h00A5, 1'b1, 8'hA5);
    add(K_WR,   16'hFF03, 16'h0001, 16'h0000, 1'b0, 8'hA5);

    foreach (vecs[i]) begin
      access(1'b0, vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0,
             $sformatf("vec%0d", i));
      check($sformatf("vec%0d err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d leds", i), leds, vecs[i].exp_leds);
    end

    // Zero wait states: write, read, then a read whose strobe lingers
    // through the RECOVER cycle.
    access(1'b1, K_WR, 16'h0010, 16'h7777, 16'h0000, 1'b0, "w0_wr");
    access(1'b1, K_RD, 16'h0010, 16'h0000, 16'h7777, 1'b0, "w0_rd");
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    rdy_n = 0; busy_n = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus0.mem_ready) rdy_n++;
      if (bus0.mem_busy) busy_n++;
      if (k == 1) begin
        check("w0_hold ready_next_cycle", bus0.mem_ready, 1);
        check("w0_hold mem_bus", bus0.mem_bus, 16'h7777);
      end
      if (k == 2) drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    check("w0_hold ready_pulses", rdy_n, 1);
    check("w0_hold busy_cycles", busy_n, 0);

    // Timer: clear, then read about ten cycles later.
    access(1'b0, K_WR, 16'hFF01, 16'h0000, 16'h0000, 1'b0, "tmr_clr");
    repeat (8) @(negedge clk);
    access(1'b0, K_RD, 16'hFF01, 16'h0000, 16'h0000, 1'b1, "tmr_rd10");
    check("tmr_rd10 value", last_rd[0], 16'd10);

    // Timer wrap: clear, then read after more than 65536 cycles.
    access(1'b0, K_WR, 16'hFF01, 16'h0000, 16'h0000, 1'b0, "wrap_clr");
    repeat (65539) @(negedge clk);
    access(1'b0, K_RD, 16'hFF01, 16'h0000, 16'h0000, 1'b1, "wrap_rd");
    check("wrap_rd value", last_rd[0], 16'd5);

    // Reset in the middle of a write's wait states.
    access(1'b0, K_WR, 16'h0020, 16'h0A0A, 16'h0000, 1'b0, "pre_wr");
    access(1'b0, K_RD, 16'h8000, 16'h0000, 16'h0000, 1'b0, "pre_err");
    check("pre_err err", err, 1);
    drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'h5555);
    @(posedge clk); @(negedge clk);
    check("midrst busy_before", bus.mem_busy, 1);
    rst = 1'b1;
    #1;
    check("midrst busy", bus.mem_busy, 0);
    check("midrst ready", bus.mem_ready, 0);
    check("midrst state", dbg, 2'd0);
    check("midrst leds", leds, 8'h00);
    check("midrst err", err, 0);
    check("midrst mem_bus", bus.mem_bus, 16'h0000);
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    access(1'b0, K_RD, 16'h0020, 16'h0000, 16'h0A0A, 1'b0, "post_rd");
    access(1'b0, K_RD, 16'hFF02, 16'h0000, 16'h0000, 1'b0, "post_scratch");
    access(1'b0, K_RD, 16'hFF00, 16'h0000, 16'h0000, 1'b0, "post_led");

    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
